// File: rtl/rx_sync_controller.sv
// Frame-level sequencer between CFO correction and time sync: gates samples into
// the search, soft-restarts it, and frames symbol reception with a guard interval.
module rx_sync_controller #(
  parameter int SEARCH_TIMEOUT = 4095,
  parameter int SYM_LEN        = 64,
  parameter int MAX_SYMBOLS    = 255,
  parameter int GUARD_CYCLES   = 16,
  parameter int STALL_TIMEOUT  = 1023
) (
  input  logic       Clk_i,
  input  logic       Rst_i,
  input  logic       Enable_i,
  input  logic       DataInEnable_i,
  input  logic       PeakFinded_i,
  input  logic       DataOutEnable_i,
  input  logic [5:0] Data_out_index_i,
  input  logic [7:0] FrameSymbols_i,
  input  logic       FrameSymbolsValid_i,
  output logic       SyncEnable_o,
  output logic       SyncRestart_o,
  output logic       FrameStart_o,
  output logic       FrameEnd_o,
  output logic       FrameAbort_o,
  output logic       SearchTimeout_o,
  output logic [7:0] SymbolCount_o,
  output logic [1:0] State_o
);

  localparam int SampleW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int StallW  = $clog2(STALL_TIMEOUT + 1);
  localparam int GuardW  = $clog2(GUARD_CYCLES + 1);

  localparam logic [SampleW-1:0] SampleLast = SampleW'(SEARCH_TIMEOUT - 1);
  localparam logic [StallW-1:0]  StallLast  = StallW'(STALL_TIMEOUT - 1);
  localparam logic [GuardW-1:0]  GuardLast  = GuardW'(GUARD_CYCLES - 1);
  localparam logic [5:0]         IndexLast  = 6'(SYM_LEN - 1);
  localparam logic [7:0]         MaxSymbols = 8'(MAX_SYMBOLS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    RECEIVE = 2'd2,
    GUARD   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [SampleW-1:0]   sampleCnt_q, sampleCnt_d;
  logic [StallW-1:0]    stallCnt_q, stallCnt_d;
  logic [GuardW-1:0]    guardCnt_q, guardCnt_d;
  logic [7:0]           symCount_q, symCount_d;
  logic [7:0]           target_q, target_d;
  logic                 targetLatched_q, targetLatched_d;
  logic                 syncRestart_q, syncRestart_d;
  logic                 searchTimeout_q, searchTimeout_d;
  logic                 frameStart_q, frameStart_d;
  logic                 frameEnd_q, frameEnd_d;
  logic                 frameAbort_q, frameAbort_d;

  logic       inIdle, inSearch, inReceive, inGuard;
  logic       searchHit, searchExpire, peakAccept;
  logic       symbolDone, frameComplete, stallExpire, guardExpire;
  logic       lengthStrobe;
  logic [7:0] symCountInc, frameSymbolsClamped, targetEff;

  assign inIdle    = (state_q == IDLE);
  assign inSearch  = (state_q == SEARCH);
  assign inReceive = (state_q == RECEIVE);
  assign inGuard   = (state_q == GUARD);

  // A peak outranks everything in SEARCH; dropping Enable outranks only the timeout.
  assign peakAccept   = inSearch && PeakFinded_i;
  assign searchHit    = DataInEnable_i && (sampleCnt_q == SampleLast);
  assign searchExpire = inSearch && !PeakFinded_i && Enable_i && searchHit;

  assign symCountInc         = (symCount_q == 8'hFF) ? 8'hFF : symCount_q + 8'd1;
  assign frameSymbolsClamped = (FrameSymbols_i == 8'd0) ? 8'd1 : FrameSymbols_i;
  assign lengthStrobe        = inReceive && FrameSymbolsValid_i && !targetLatched_q;
  assign targetEff           = lengthStrobe ? frameSymbolsClamped : target_q;

  assign symbolDone    = inReceive && DataOutEnable_i && (Data_out_index_i == IndexLast);
  assign frameComplete = symbolDone && (symCountInc >= targetEff);
  assign stallExpire   = inReceive && !DataOutEnable_i && (stallCnt_q == StallLast);
  assign guardExpire   = inGuard && (guardCnt_q == GuardLast);

  assign SyncEnable_o    = DataInEnable_i && (inSearch || inReceive);
  assign SyncRestart_o   = syncRestart_q;
  assign SearchTimeout_o = searchTimeout_q;
  assign FrameStart_o    = frameStart_q;
  assign FrameEnd_o      = frameEnd_q;
  assign FrameAbort_o    = frameAbort_q;
  assign SymbolCount_o   = symCount_q;
  assign State_o         = state_q;

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (Enable_i) begin
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        if (PeakFinded_i) begin
          state_d = RECEIVE;
        end else if (!Enable_i) begin
          state_d = IDLE;
        end
      end
      RECEIVE: begin
        if (frameComplete || stallExpire) begin
          state_d = GUARD;
        end
      end
      GUARD: begin
        if (guardExpire) begin
          state_d = Enable_i ? SEARCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    syncRestart_d   = (inIdle && Enable_i) || searchExpire || guardExpire;
    searchTimeout_d = searchExpire;
    frameStart_d    = peakAccept;
    frameEnd_d      = frameComplete || stallExpire;
    frameAbort_d    = stallExpire && !frameComplete;

    sampleCnt_d = sampleCnt_q;
    if (!inSearch || PeakFinded_i || !Enable_i || searchHit) begin
      sampleCnt_d = '0;
    end else if (DataInEnable_i) begin
      sampleCnt_d = sampleCnt_q + SampleW'(1);
    end

    stallCnt_d = stallCnt_q + StallW'(1);
    if (!inReceive || DataOutEnable_i || stallExpire) begin
      stallCnt_d = '0;
    end

    guardCnt_d = guardCnt_q + GuardW'(1);
    if (!inGuard || guardExpire) begin
      guardCnt_d = '0;
    end

    // SymbolCount is left untouched after the frame so it can be read through GUARD.
    symCount_d = symCount_q;
    if (peakAccept) begin
      symCount_d = 8'd0;
    end else if (symbolDone) begin
      symCount_d = symCountInc;
    end

    target_d        = target_q;
    targetLatched_d = targetLatched_q;
    if (peakAccept) begin
      target_d        = MaxSymbols;
      targetLatched_d = 1'b0;
    end else if (lengthStrobe) begin
      target_d        = frameSymbolsClamped;
      targetLatched_d = 1'b1;
    end
  end

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      sampleCnt_q     <= '0;
      stallCnt_q      <= '0;
      guardCnt_q      <= '0;
      symCount_q      <= 8'd0;
      target_q        <= MaxSymbols;
      targetLatched_q <= 1'b0;
      syncRestart_q   <= 1'b0;
      searchTimeout_q <= 1'b0;
      frameStart_q    <= 1'b0;
      frameEnd_q      <= 1'b0;
      frameAbort_q    <= 1'b0;
    end else begin
      sampleCnt_q     <= sampleCnt_d;
      stallCnt_q      <= stallCnt_d;
      guardCnt_q      <= guardCnt_d;
      symCount_q      <= symCount_d;
      target_q        <= target_d;
      targetLatched_q <= targetLatched_d;
      syncRestart_q   <= syncRestart_d;
      searchTimeout_q <= searchTimeout_d;
      frameStart_q    <= frameStart_d;
      frameEnd_q      <= frameEnd_d;
      frameAbort_q    <= frameAbort_d;
    end
  end

endmodule

// File: tb/tb_rx_sync_controller.sv
// Bench for rx_sync_controller: constant vector table, directed frame/timeout/stall
// sequences and a randomized run compared against a rule-level reference model.
module tb_rx_sync_controller;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       Enable = 1'b0;
  logic       DataInEnable = 1'b0;
  logic       PeakFinded = 1'b0;
  logic       DataOutEnable = 1'b0;
  logic [5:0] DataOutIndex = 6'd0;
  logic [7:0] FrameSymbols = 8'd0;
  logic       FrameSymbolsValid = 1'b0;
  logic       SyncEnable, SyncRestart, FrameStart, FrameEnd, FrameAbort, SearchTimeout;
  logic [7:0] SymbolCount;
  logic [1:0] State;

  rx_sync_controller dut (
    .Clk_i               (Clk),
    .Rst_i               (Rst),
    .Enable_i            (Enable),
    .DataInEnable_i      (DataInEnable),
    .PeakFinded_i        (PeakFinded),
    .DataOutEnable_i     (DataOutEnable),
    .Data_out_index_i    (DataOutIndex),
    .FrameSymbols_i      (FrameSymbols),
    .FrameSymbolsValid_i (FrameSymbolsValid),
    .SyncEnable_o        (SyncEnable),
    .SyncRestart_o       (SyncRestart),
    .FrameStart_o        (FrameStart),
    .FrameEnd_o          (FrameEnd),
    .FrameAbort_o        (FrameAbort),
    .SearchTimeout_o     (SearchTimeout),
    .SymbolCount_o       (SymbolCount),
    .State_o             (State)
  );

  always #5 Clk = ~Clk;

  int errorCount = 0;
  int checkCount = 0;
  int seenRestart = 0;
  int seenTimeout = 0;
  bit lastSyncEn;

  // Reference model: mode uses the externally visible State values; counters run in
  // plain integers (guard counts down, samples/quiet count up toward their limits).
  int mMode, mSamples, mSymbols, mTarget, mQuiet, mGuardLeft;
  bit mLengthKnown, mRestart, mTimeout, mStart, mEnd, mAbort;

  typedef struct {
    bit       rstFirst;
    bit       en, die, peak, doe;
    bit [5:0] idx;
    bit [7:0] fs;
    bit       fsv;
    bit       expSyncEn;
    int       expState;
    int       expCount;
    bit [4:0] expPulse;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mkVec(input int r, input int en, input int die, input int peak,
                                 input int doe, input int idx, input int fs, input int fsv,
                                 input int sy, input int st, input int cnt, input bit [4:0] p);
    vec_t v;
    v.rstFirst = r[0];  v.en = en[0];   v.die = die[0]; v.peak = peak[0];
    v.doe = doe[0];     v.idx = 6'(idx); v.fs = 8'(fs); v.fsv = fsv[0];
    v.expSyncEn = sy[0]; v.expState = st; v.expCount = cnt; v.expPulse = p;
    return v;
  endfunction

  function automatic int dutPack();
    return (int'(State) << 13) | (int'(SymbolCount) << 5) | (int'(SyncRestart) << 4) |
           (int'(SearchTimeout) << 3) | (int'(FrameStart) << 2) | (int'(FrameEnd) << 1) |
           int'(FrameAbort);
  endfunction

  function automatic int modelPack();
    return (mMode << 13) | (mSymbols << 5) | (int'(mRestart) << 4) | (int'(mTimeout) << 3) |
           (int'(mStart) << 2) | (int'(mEnd) << 1) | int'(mAbort);
  endfunction

  task automatic modelReset();
    mMode = 0; mSamples = 0; mSymbols = 0; mTarget = 255; mQuiet = 0; mGuardLeft = 0;
    mLengthKnown = 0; mRestart = 0; mTimeout = 0; mStart = 0; mEnd = 0; mAbort = 0;
  endtask

  task automatic modelStep(input bit en, input bit die, input bit peak, input bit doe,
                           input bit [5:0] idx, input bit [7:0] fs, input bit fsv);
    mRestart = 0; mTimeout = 0; mStart = 0; mEnd = 0; mAbort = 0;
    case (mMode)
      0: if (en) begin mMode = 1; mSamples = 0; mRestart = 1; end
      1: begin
        if (peak) begin
          mMode = 2; mStart = 1; mSymbols = 0; mQuiet = 0; mLengthKnown = 0; mTarget = 255;
        end else if (!en) begin
          mMode = 0;
        end else if (die) begin
          mSamples++;
          if (mSamples == 4095) begin mTimeout = 1; mRestart = 1; mSamples = 0; end
        end
      end
      2: begin
        if (fsv && !mLengthKnown) begin
          mTarget = (fs == 0) ? 1 : int'(fs);
          mLengthKnown = 1;
        end
        if (doe) begin
          mQuiet = 0;
          if (idx == 63) begin
            mSymbols = (mSymbols < 255) ? mSymbols + 1 : 255;
            if (mSymbols >= mTarget) begin mMode = 3; mGuardLeft = 16; mEnd = 1; end
          end
        end else begin
          mQuiet++;
          if (mQuiet == 1023) begin mMode = 3; mGuardLeft = 16; mEnd = 1; mAbort = 1; end
        end
      end
      default: begin
        mGuardLeft--;
        if (mGuardLeft == 0) begin mRestart = 1; mMode = en ? 1 : 0; mSamples = 0; end
      end
    endcase
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit en, input bit die, input bit peak, input bit doe,
                               input bit [5:0] idx, input bit [7:0] fs, input bit fsv);
    @(negedge Clk);
    Enable = en; DataInEnable = die; PeakFinded = peak; DataOutEnable = doe;
    DataOutIndex = idx; FrameSymbols = fs; FrameSymbolsValid = fsv;
    #1;
    lastSyncEn = SyncEnable;
    checkOutput("model_syncen", int'(SyncEnable), (die && (mMode == 1 || mMode == 2)) ? 1 : 0);
    modelStep(en, die, peak, doe, idx, fs, fsv);
    @(posedge Clk);
    #1;
    checkOutput("model_outs", dutPack(), modelPack());
    if (SyncRestart) seenRestart++;
    if (SearchTimeout) seenTimeout++;
  endtask

  task automatic idle(input bit en, input bit die);
    applyStimulus(en, die, 1'b0, 1'b0, 6'd0, 8'd0, 1'b0);
  endtask

  task automatic sendSymbol(input int sA, input bit [7:0] fA, input int sB, input bit [7:0] fB);
    for (int i = 0; i < 64; i++) begin
      if (i == sA)      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'(i), fA, 1'b1);
      else if (i == sB) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'(i), fB, 1'b1);
      else              applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 6'(i), 8'd0, 1'b0);
    end
  endtask

  task automatic doReset(input bit checkValues, input string tag);
    @(negedge Clk);
    Enable = 0; DataInEnable = 1; PeakFinded = 0; DataOutEnable = 0;
    DataOutIndex = 0; FrameSymbols = 0; FrameSymbolsValid = 0;
    #2 Rst = 1'b1;
    #1;
    if (checkValues) begin
      checkOutput({tag, "_state"}, int'(State), 0);
      checkOutput({tag, "_count"}, int'(SymbolCount), 0);
      checkOutput({tag, "_pulses"}, dutPack() & 31, 0);
      checkOutput({tag, "_syncen"}, int'(SyncEnable), 0);
    end
    @(posedge Clk);
    @(negedge Clk);
    Rst = 1'b0;
    modelReset();
    seenRestart = 0;
    seenTimeout = 0;
  endtask

  task automatic enterReceive();
    idle(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 8'd0, 1'b0);
  endtask

  initial begin
    int firstTo, secondTo, guardLen;
    modelReset();
    vecs[0]  = mkVec(0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 5'b00000);
    vecs[1]  = mkVec(0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0, 5'b10000);
    vecs[2]  = mkVec(0, 1, 1, 0, 0,  0, 0, 0, 1, 1, 0, 5'b00000);
    vecs[3]  = mkVec(0, 1, 0, 1, 0,  0, 0, 0, 0, 2, 0, 5'b00100);
    vecs[4]  = mkVec(0, 1, 1, 0, 1, 10, 3, 1, 1, 2, 0, 5'b00000);
    vecs[5]  = mkVec(0, 1, 0, 0, 1, 63, 1, 1, 0, 2, 1, 5'b00000);
    vecs[6]  = mkVec(0, 1, 0, 0, 1, 63, 0, 0, 0, 2, 2, 5'b00000);
    vecs[7]  = mkVec(0, 0, 1, 0, 1, 63, 0, 0, 1, 3, 3, 5'b00010);
    vecs[8]  = mkVec(0, 0, 1, 1, 1, 63, 0, 1, 0, 3, 3, 5'b00000);
    vecs[9]  = mkVec(1, 1, 0, 0, 0,  0, 0, 0, 0, 1, 0, 5'b10000);
    vecs[10] = mkVec(0, 1, 1, 1, 0,  0, 0, 0, 1, 2, 0, 5'b00100);
    vecs[11] = mkVec(0, 1, 0, 0, 0,  0, 0, 1, 0, 2, 0, 5'b00000);
    vecs[12] = mkVec(0, 1, 0, 0, 1, 63, 0, 0, 0, 3, 1, 5'b00010);
    vecs[13] = mkVec(0, 1, 0, 0, 1, 62, 0, 0, 0, 3, 1, 5'b00000);

    $display("[TB] vector table");
    Rst = 1'b1;
    #12 Rst = 1'b0;
    doReset(1'b1, "reset");
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rstFirst) doReset(1'b1, $sformatf("vec%0d_reset", i));
      applyStimulus(vecs[i].en, vecs[i].die, vecs[i].peak, vecs[i].doe,
                    vecs[i].idx, vecs[i].fs, vecs[i].fsv);
      checkOutput($sformatf("vec%0d_syncen", i), int'(lastSyncEn), int'(vecs[i].expSyncEn));
      checkOutput($sformatf("vec%0d_outs", i), dutPack(),
                  (vecs[i].expState << 13) | (vecs[i].expCount << 5) | int'(vecs[i].expPulse));
    end

    $display("[TB] peak at sample 300");
    doReset(1'b0, "r");
    idle(1'b1, 1'b1);
    for (int s = 1; s < 300; s++) idle(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 8'd0, 1'b0);
    checkOutput("peak300_state", int'(State), 2);
    checkOutput("peak300_start", int'(FrameStart), 1);
    checkOutput("peak300_restarts", seenRestart, 1);
    checkOutput("peak300_timeouts", seenTimeout, 0);

    $display("[TB] search timeout");
    doReset(1'b0, "r");
    idle(1'b1, 1'b0);
    firstTo = 0; secondTo = 0;
    for (int s = 1; s <= 8190; s++) begin
      idle(1'b1, 1'b1);
      if (SearchTimeout) begin
        checkOutput("timeout_with_restart", int'(SyncRestart), 1);
        if (firstTo == 0) firstTo = s; else secondTo = s;
      end
    end
    checkOutput("timeout_first_sample", firstTo, 4095);
    checkOutput("timeout_second_sample", secondTo, 8190);
    checkOutput("timeout_state", int'(State), 1);

    $display("[TB] five-symbol frame and guard");
    doReset(1'b0, "r");
    enterReceive();
    for (int k = 0; k < 5; k++) sendSymbol((k == 0) ? 10 : -1, 8'd5, -1, 8'd0);
    checkOutput("frame5_end", int'(FrameEnd), 1);
    checkOutput("frame5_count", int'(SymbolCount), 5);
    checkOutput("frame5_state", int'(State), 3);
    guardLen = 1;
    for (int k = 0; k < 40 && State == 2'd3; k++) begin
      idle(1'b1, 1'b0);
      if (State == 2'd3) guardLen++;
    end
    checkOutput("guard_cycles", guardLen, 16);
    checkOutput("guard_exit_state", int'(State), 1);
    checkOutput("guard_exit_restart", int'(SyncRestart), 1);
    checkOutput("guard_hold_count", int'(SymbolCount), 5);

    $display("[TB] late frame length");
    doReset(1'b0, "r");
    enterReceive();
    for (int k = 0; k < 3; k++) sendSymbol(-1, 8'd0, -1, 8'd0);
    checkOutput("late_count3", int'(SymbolCount), 3);
    checkOutput("late_still_rx", int'(State), 2);
    sendSymbol(5, 8'd2, 20, 8'd9);
    checkOutput("late_end", int'(FrameEnd), 1);
    checkOutput("late_count", int'(SymbolCount), 4);
    checkOutput("late_state", int'(State), 3);

    $display("[TB] stall abort");
    doReset(1'b0, "r");
    enterReceive();
    for (int k = 0; k < 1022; k++) idle(1'b1, 1'b1);
    checkOutput("stall_before_state", int'(State), 2);
    checkOutput("stall_before_end", int'(FrameEnd), 0);
    idle(1'b1, 1'b1);
    checkOutput("stall_state", int'(State), 3);
    checkOutput("stall_end", int'(FrameEnd), 1);
    checkOutput("stall_abort", int'(FrameAbort), 1);
    for (int k = 0; k < 15; k++) idle(1'b0, 1'b1);
    checkOutput("stall_guard_state", int'(State), 3);
    idle(1'b0, 1'b1);
    checkOutput("stall_exit_state", int'(State), 0);
    checkOutput("stall_exit_restart", int'(SyncRestart), 1);
    idle(1'b0, 1'b1);
    checkOutput("idle_syncen", int'(lastSyncEn), 0);

    $display("[TB] reset mid-receive");
    doReset(1'b0, "r");
    enterReceive();
    for (int k = 0; k < 3; k++) sendSymbol(-1, 8'd0, -1, 8'd0);
    checkOutput("midrst_count_before", int'(SymbolCount), 3);
    doReset(1'b1, "midrst");
    idle(1'b0, 1'b0);
    checkOutput("midrst_after", dutPack(), 0);

    $display("[TB] peak and timeout in the same cycle");
    doReset(1'b0, "r");
    idle(1'b1, 1'b0);
    for (int s = 1; s < 4095; s++) idle(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 8'd0, 1'b0);
    checkOutput("coinc_state", int'(State), 2);
    checkOutput("coinc_start", int'(FrameStart), 1);
    checkOutput("coinc_timeout", int'(SearchTimeout), 0);
    checkOutput("coinc_restart", int'(SyncRestart), 0);

    $display("[TB] randomized run");
    doReset(1'b0, "r");
    for (int blk = 0; blk < 24; blk++) begin
      int regime;
      regime = int'($urandom_range(0, 3));
      for (int c = 0; c < 1200; c++) begin
        bit en, die, peak, doe, fsv;
        bit [5:0] idx;
        bit [7:0] fs;
        en   = ($urandom_range(0, 99) < 97);
        die  = ($urandom_range(0, 3) != 0);
        peak = (regime != 2) && ($urandom_range(0, 299) == 0);
        doe  = (regime == 1) ? 1'b0 : ($urandom_range(0, 9) < 7);
        idx  = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 62));
        fs   = 8'($urandom_range(0, 7));
        fsv  = ($urandom_range(0, 49) == 0);
        applyStimulus(en, die, peak, doe, idx, fs, fsv);
      end
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rx_sync_controller.md
Name: rx_sync_controller

Overview:
- Frame-level sequencer for the OFDM receive time-synchronisation datapath, between the CFO correction stage and the time-sync block.
- Gates samples into time sync and soft-restarts it after timeouts or completed frames.
- Converts the one-shot STS-end indication into framed symbol reception: frame start, symbol counting, frame end.
- Enforces a guard interval before re-arming the search.

Parameters:
SEARCH_TIMEOUT, 4095, valid input samples allowed in SEARCH without a peak before restart
SYM_LEN, 64, samples per symbol at the time-sync output; Data_out_index wraps at SYM_LEN-1
MAX_SYMBOLS, 255, symbol limit used when no frame length has been supplied
GUARD_CYCLES, 16, idle clock cycles between frame end and re-arm
STALL_TIMEOUT, 1023, clock cycles in RECEIVE without DataOutEnable before abort

Ports:
Clk  in  1  module clock
Rst  in  1  asynchronous reset, active-high
Enable  in  1  receiver enable (level)
DataInEnable  in  1  sample valid from CFO stage
PeakFinded  in  1  one-cycle pulse from time sync: STS end located
DataOutEnable  in  1  time-sync output sample valid
Data_out_index  in  6  time-sync output sample index within symbol
FrameSymbols  in  8  frame length in symbols from header decode
FrameSymbolsValid  in  1  one-cycle strobe qualifying FrameSymbols
SyncEnable  out  1  gated sample enable to time sync
SyncRestart  out  1  one-cycle soft-restart pulse to time sync
FrameStart  out  1  one-cycle pulse, frame acquired
FrameEnd  out  1  one-cycle pulse, frame completed or aborted
FrameAbort  out  1  one-cycle pulse coincident with FrameEnd on stall abort
SearchTimeout  out  1  one-cycle pulse, search expired
SymbolCount  out  8  completed symbols in current frame
State  out  2  IDLE=0, SEARCH=1, RECEIVE=2, GUARD=3

Behaviour:
- Reset: State=IDLE; all pulses 0; SymbolCount=0; all counters 0; target=MAX_SYMBOLS; latch flag cleared.
- SyncEnable is combinational: DataInEnable AND (State==SEARCH or RECEIVE). It is 0 in IDLE and GUARD.
- All other outputs are registered; pulses last exactly one cycle.

State transitions:
- IDLE: Enable=1 -> SEARCH; SyncRestart pulses on the cycle State becomes SEARCH; sample counter cleared.
- SEARCH, sample counting: the counter increments on each DataInEnable.
- SEARCH, peak: PeakFinded -> RECEIVE; FrameStart pulses the next cycle; SymbolCount, stall counter and latch flag cleared; target=MAX_SYMBOLS.
- SEARCH, timeout: counter reaches SEARCH_TIMEOUT -> SearchTimeout and SyncRestart pulse together; counter clears; remain in SEARCH.
- SEARCH, priority: PeakFinded in the same cycle as the timeout -> the peak wins and there is no timeout pulse.
- SEARCH, disable: Enable=0 -> IDLE with no pulses. Enable has priority over the timeout but not over PeakFinded.
- RECEIVE, symbol completion: DataOutEnable with Data_out_index==SYM_LEN-1. SymbolCount saturates at 255.
- RECEIVE, frame length: the first FrameSymbolsValid latches the target; later strobes in the same frame are ignored. FrameSymbols=0 is latched as 1.
- RECEIVE, end: a symbol completion that makes SymbolCount >= target -> GUARD, with FrameEnd on the next cycle.
- RECEIVE, late length: if the latched target is <= the current SymbolCount, the frame ends at the next completion.
- RECEIVE, Enable=0: the current frame finishes normally; no abort.
- RECEIVE, stall: the stall counter clears on every DataOutEnable and otherwise increments. Reaching STALL_TIMEOUT -> GUARD with FrameEnd and FrameAbort.
- RECEIVE, stall vs completion: stall abort and symbol completion in the same cycle -> completion handling wins.
- GUARD: counts GUARD_CYCLES clocks. On expiry it issues SyncRestart, then goes to SEARCH if Enable=1, else IDLE.
- SymbolCount holds its final value through GUARD and clears on the next FrameStart.
- PeakFinded, DataOutEnable and FrameSymbolsValid are ignored in IDLE and GUARD.
- Rst asserted in any state returns immediately to reset values. No pulse is emitted on deassertion.

Test Plan:
- Enable=1, continuous DataInEnable, PeakFinded at sample 300 -> one SyncRestart on entering SEARCH; FrameStart 1 cycle after peak; State=2; SearchTimeout never asserted.
- Enable=1, no peak, 4095 valid samples -> SearchTimeout and SyncRestart coincide on the counter-expiry cycle; repeat at 8190; State stays 1.
- After peak, FrameSymbols=5 strobed during symbol 1, 5 full symbols streamed -> FrameEnd after 5th index-63 sample; SymbolCount=5; State=3 for 16 cycles; then SyncRestart and State=1.
- FrameSymbols=2 strobed after 3 symbols completed -> FrameEnd after the 4th completion; SymbolCount=4. Second strobe of 9 ignored.
- In RECEIVE, DataOutEnable held low 1023 cycles -> FrameEnd and FrameAbort together; GUARD; Enable=0 -> IDLE with SyncEnable=0.
- Rst pulsed mid-RECEIVE at SymbolCount=3 -> State=0, SymbolCount=0, no pulses; PeakFinded and timeout in the same SEARCH cycle -> FrameStart only.
